// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int GPR_ADDR_W = 5
);
    logic [GPR_ADDR_W-1:0] dec_rs1_addr;
    logic [GPR_ADDR_W-1:0] dec_rs2_addr;
    logic                  dec_rs1_used;
    logic                  dec_rs2_used;
    logic                  id_en;
    logic                  id_gpr_we_;
    logic [GPR_ADDR_W-1:0] id_dst_addr;
    logic                  id_is_load;
    logic                  br_taken;
    logic                  mc_start;
    logic                  mem_busy;

    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_stall;
    logic                  idex_flush;
    logic                  exmem_stall;
    logic                  exmem_flush;
    logic                  mc_done;
    logic                  bus_err;
    logic [1:0]            ctrl_state;

    modport master (
        output dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
        output id_en, id_gpr_we_, id_dst_addr, id_is_load,
        output br_taken, mc_start, mem_busy,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
        input  exmem_stall, exmem_flush, mc_done, bus_err, ctrl_state
    );

    modport slave (
        input  dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
        input  id_en, id_gpr_we_, id_dst_addr, id_is_load,
        input  br_taken, mc_start, mem_busy,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
        output exmem_stall, exmem_flush, mc_done, bus_err, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the in-order pipeline: load-use and branch hazards,
// multicycle-op freeze, data-memory wait freeze and memory-timeout abort.
module pipe_hazard_ctrl #(
    parameter int GPR_ADDR_W  = 5,
    parameter int MC_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    pipe_hazard_ctrl_if.slave        hz
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_ABORT   = 2'd2
    } state_t;

    localparam logic [3:0] MC_LOAD   = 4'(MC_LATENCY - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [3:0] mc_cnt;
    logic [7:0] wait_cnt;

    logic [GPR_ADDR_W-1:0] dst_addr;
    logic [GPR_ADDR_W-1:0] rs1_addr;
    logic [GPR_ADDR_W-1:0] rs2_addr;

    logic in_abort;
    logic in_mc;
    logic in_run;
    logic timeout;
    logic mc_hold;
    logic mc_fin;
    logic mc_go;
    logic load_use;

    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic mc_done;
    logic bus_err;

    assign dst_addr = hz.id_dst_addr;
    assign rs1_addr = hz.dec_rs1_addr;
    assign rs2_addr = hz.dec_rs2_addr;

    // Encoding 3 is unreachable; anything that is not MC_BUSY or ABORT behaves as RUN.
    assign in_abort = (state == ST_ABORT);
    assign in_mc    = (state == ST_MC_BUSY);
    assign in_run   = !in_abort && !in_mc;

    assign timeout  = hz.mem_busy && (wait_cnt == WAIT_LAST);
    assign mc_hold  = in_mc && (mc_cnt != 4'd0);
    assign mc_fin   = in_mc && (mc_cnt == 4'd0);
    assign mc_go    = in_run && hz.mc_start && hz.id_en;

    assign load_use = hz.id_en && hz.id_is_load && !hz.id_gpr_we_ &&
                      (dst_addr != '0) &&
                      ((hz.dec_rs1_used && (rs1_addr == dst_addr)) ||
                       (hz.dec_rs2_used && (rs2_addr == dst_addr)));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        bus_err     = 1'b0;

        if (in_abort) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz.mem_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            bus_err     = timeout;
        end else if (mc_hold || mc_go) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
        end else if (in_run && hz.id_en && hz.br_taken) begin
            // Redirect: the PC must load the target, so it is not held.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (in_run && load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // A timeout that coincides with the final MC cycle aborts the op, so no completion pulse.
    assign mc_done = mc_fin && !timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            mc_cnt   <= 4'd0;
            wait_cnt <= 8'd0;
        end else begin
            if (hz.mem_busy && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end

            case (state)
                ST_ABORT: begin
                    state  <= ST_RUN;
                    mc_cnt <= 4'd0;
                end
                ST_MC_BUSY: begin
                    if (timeout) begin
                        state  <= ST_ABORT;
                        mc_cnt <= 4'd0;
                    end else if (mc_cnt == 4'd0) begin
                        state  <= ST_RUN;
                    end else begin
                        mc_cnt <= mc_cnt - 4'd1;
                    end
                end
                default: begin
                    if (timeout) begin
                        state  <= ST_ABORT;
                        mc_cnt <= 4'd0;
                    end else if (mc_go) begin
                        state  <= ST_MC_BUSY;
                        mc_cnt <= MC_LOAD;
                    end
                end
            endcase
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.ifid_stall  = ifid_stall;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_stall  = idex_stall;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_stall = exmem_stall;
    assign hz.exmem_flush = exmem_flush;
    assign hz.mc_done     = mc_done;
    assign hz.bus_err     = bus_err;
    assign hz.ctrl_state  = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed output vectors.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pipe_hazard_ctrl_if #(.GPR_ADDR_W(5)) hz ();

    pipe_hazard_ctrl #(
        .GPR_ADDR_W (5),
        .MC_LATENCY (4),
        .MEM_TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz.slave)
    );

    always #5 clk = ~clk;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //  exmem_stall, exmem_flush, mc_done, bus_err, ctrl_state[1:0]}
    localparam logic [10:0] NONE    = 11'b0_0_0_0_0_0_0_0_0_00;
    localparam logic [10:0] STALL4  = 11'b1_1_0_1_0_1_0_0_0_00;
    localparam logic [10:0] MCSTALL = 11'b1_1_0_1_0_0_0_0_0_00;
    localparam logic [10:0] LU      = 11'b1_1_0_0_1_0_0_0_0_00;
    localparam logic [10:0] BR      = 11'b0_0_1_0_1_0_0_0_0_00;
    localparam logic [10:0] FL3     = 11'b0_0_1_0_1_0_1_0_0_00;
    localparam logic [10:0] DONE    = 11'b0_0_0_0_0_0_0_1_0_00;
    localparam logic [10:0] BERR    = 11'b0_0_0_0_0_0_0_0_1_00;
    localparam logic [10:0] ST1     = 11'b0_0_0_0_0_0_0_0_0_01;
    localparam logic [10:0] ST2     = 11'b0_0_0_0_0_0_0_0_0_10;

    function automatic logic [10:0] obs_vec();
        return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                hz.idex_flush, hz.exmem_stall, hz.exmem_flush, hz.mc_done,
                hz.bus_err, hz.ctrl_state};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] o;
        #1;
        o = obs_vec();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.dec_rs1_addr = '0;
        hz.dec_rs2_addr = '0;
        hz.dec_rs1_used = 1'b0;
        hz.dec_rs2_used = 1'b0;
        hz.id_en        = 1'b0;
        hz.id_gpr_we_   = 1'b1;
        hz.id_dst_addr  = '0;
        hz.id_is_load   = 1'b0;
        hz.br_taken     = 1'b0;
        hz.mc_start     = 1'b0;
        hz.mem_busy     = 1'b0;
    endtask

    task automatic load_in_idex(input logic [4:0] dst);
        hz.id_en       = 1'b1;
        hz.id_is_load  = 1'b1;
        hz.id_gpr_we_  = 1'b0;
        hz.id_dst_addr = dst;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        check("reset_idle", NONE);
        step();
        step();
        reset = 1'b1;
        check("post_reset_idle", NONE);
        step();

        // Load-use on rs2: one cycle, then the bubble occupies ID/EX.
        load_in_idex(5'd5);
        hz.dec_rs2_addr = 5'd5;
        hz.dec_rs2_used = 1'b1;
        check("lu_rs2_x5", LU);
        step();
        hz.id_en = 1'b0;
        hz.id_gpr_we_ = 1'b1;
        check("lu_bubble_clears", NONE);
        step();

        load_in_idex(5'd0);
        hz.dec_rs2_addr = 5'd0;
        check("lu_dst_x0", NONE);
        load_in_idex(5'd5);
        hz.dec_rs2_addr = 5'd5;
        hz.id_gpr_we_ = 1'b1;
        check("lu_no_write", NONE);
        hz.id_gpr_we_ = 1'b0;
        hz.dec_rs2_used = 1'b0;
        check("lu_rs2_unused", NONE);
        hz.dec_rs1_addr = 5'd5;
        hz.dec_rs1_used = 1'b1;
        check("lu_rs1_x5", LU);
        hz.br_taken = 1'b1;
        check("br_over_lu", BR);
        hz.id_en = 1'b0;
        check("br_no_id_en", NONE);
        step();
        idle();

        // Multicycle op: stalls T..T+3, mc_done at T+4.
        hz.mc_start = 1'b1;
        hz.id_en    = 1'b1;
        check("mc_T0", MCSTALL);
        step();
        check("mc_T1", MCSTALL | ST1);
        step();
        check("mc_T2", MCSTALL | ST1);
        step();
        check("mc_T3", MCSTALL | ST1);
        step();
        check("mc_T4_done", DONE | ST1);
        step();
        idle();
        check("mc_T5_run", NONE);
        step();

        // Multicycle op with 10 cycles of mem_busy from T+1.
        hz.mc_start = 1'b1;
        hz.id_en    = 1'b1;
        check("mcm_T0", MCSTALL);
        step();
        hz.mem_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                hz.mc_start = 1'b0;
                hz.id_en    = 1'b0;
            end
            if (k < 4)       check($sformatf("mcm_T%0d", k), STALL4 | ST1);
            else if (k == 4) check("mcm_T4_done", STALL4 | DONE | ST1);
            else             check($sformatf("mcm_T%0d", k), STALL4);
            step();
        end
        hz.mem_busy = 1'b0;
        check("mcm_release", NONE);
        step();

        // Memory timeout with a multicycle op started late in the wait.
        hz.mem_busy = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            hz.mc_start = (k == 62);
            hz.id_en    = (k == 62);
            if (k < 63)       check($sformatf("busy_%0d", k), STALL4);
            else if (k == 63) check("busy_63", STALL4 | ST1);
            else              check("busy_64_timeout", STALL4 | BERR | ST1);
            step();
        end
        hz.mem_busy = 1'b0;
        check("abort_cycle", FL3 | ST2);
        step();
        check("after_abort_run", NONE);
        step();
        check("no_late_mc_done", NONE);
        step();

        // Asynchronous reset mid-MC_BUSY with mc_cnt=2.
        hz.mc_start = 1'b1;
        hz.id_en    = 1'b1;
        step();
        step();
        idle();
        check("mc_cnt2_busy", MCSTALL | ST1);
        reset = 1'b0;
        check("async_reset_mid_mc", NONE);
        step();
        reset = 1'b1;
        check("post_reset_mc_gone", NONE);
        step();
        check("post_reset_idle2", NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
